// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit -- iterative multiply/divide unit with HI/LO registers.
//
// Executes MULT/MULTU/DIV/DIVU one radix-2 step per cycle (shift-add for
// multiply, restoring shift-subtract for divide) on operand magnitudes, then
// applies sign correction in a final FIX cycle and writes HI/LO. Also
// services MTHI/MTLO writes while idle.
//
// Optional feature macro: MULDIV_FAST_MUL_EN
//   defined   : MULT/MULTU finish combinationally in the FIX cycle (latency 1)
//   undefined : multiply is iterative like divide (latency WIDTH+1)
//
// Parameters:
//   WIDTH  operand and HI/LO width (even, >= 4)
//   CNT_W  iteration counter width
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-high reset
//   start     request new operation (accepted only when busy=0)
//   op        00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b      multiplicand/dividend, multiplier/divisor
//   hi_we     MTHI write enable (idle only)
//   lo_we     MTLO write enable (idle only)
//   wdata     MTHI/MTLO write data
//   busy      operation in progress
//   done      one-cycle pulse, HI/LO updated by an operation
//   div_zero  last division had b=0; held until the next accept
//   hi, lo    HI/LO architectural registers
// ---------------------------------------------------------------------------
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state, state_nxt;
    logic               is_div;     // latched op[1]
    logic [WIDTH:0]     mag_a;      // |a| (or raw a), one extra bit so |MIN| is exact
    logic [WIDTH:0]     mag_b;
    logic [WIDTH:0]     rem;        // product upper half / partial remainder
    logic [WIDTH-1:0]   quo;        // multiplier bits / dividend bits -> quotient
    logic               neg_q;      // negate product or quotient
    logic               neg_r;      // negate remainder (dividend sign)
    logic               b_zero;
    logic [CNT_W-1:0]   cnt;

    // Operand conditioning: sign-extend by one bit for signed ops, then take
    // the magnitude in WIDTH+1 bits.
    logic               is_signed;
    logic [WIDTH:0]     a_ext, b_ext, abs_a, abs_b;

    // Per-step datapath.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic               last_step;

    // Result formatting in FIX.
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0]   q_s, r_s;

    assign busy      = (state != IDLE);
    assign is_signed = ~op[0];
    assign last_step = (cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a value
        // first so no path leaves it unassigned and a latch is never inferred.
        a_ext    = {is_signed & a[WIDTH-1], a};
        b_ext    = {is_signed & b[WIDTH-1], b};
        abs_a    = a_ext[WIDTH] ? -a_ext : a_ext;
        abs_b    = b_ext[WIDTH] ? -b_ext : b_ext;

        mul_sum  = rem + (quo[0] ? mag_a : '0);
        div_sh   = {rem[WIDTH-1:0], quo[WIDTH-1]};
        div_diff = div_sh - mag_b;
        div_ge   = (div_sh >= mag_b);

`ifdef MULDIV_FAST_MUL_EN
        prod     = {{WIDTH{1'b0}}, mag_a[WIDTH-1:0]} * {{WIDTH{1'b0}}, mag_b[WIDTH-1:0]};
`else
        prod     = {rem[WIDTH-1:0], quo};
`endif
        prod_s   = neg_q ? -prod : prod;
        q_s      = neg_q ? -quo : quo;
        r_s      = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
`ifdef MULDIV_FAST_MUL_EN
                    state_nxt = op[1] ? RUN : FIX;
`else
                    state_nxt = RUN;
`endif
                end
            end
            RUN:     if (last_step) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            is_div   <= 1'b0;
            mag_a    <= '0;
            mag_b    <= '0;
            rem      <= '0;
            quo      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            b_zero   <= 1'b0;
            cnt      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // An MT write coincident with an accept still lands; the
                    // operation result overwrites it at FIX.
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start) begin
                        is_div   <= op[1];
                        mag_a    <= abs_a;
                        mag_b    <= abs_b;
                        neg_q    <= a_ext[WIDTH] ^ b_ext[WIDTH];
                        neg_r    <= a_ext[WIDTH];
                        b_zero   <= (b == '0);
                        rem      <= '0;
                        quo      <= op[1] ? abs_a[WIDTH-1:0] : abs_b[WIDTH-1:0];
                        cnt      <= '0;
                        div_zero <= 1'b0;
                    end
                end
                RUN: begin
                    cnt <= cnt + CNT_W'(1);
                    if (is_div) begin
                        // Restoring step; with b=0 every step subtracts zero,
                        // leaving quotient all ones and remainder |a|.
                        rem <= div_ge ? div_diff : div_sh;
                        quo <= {quo[WIDTH-2:0], div_ge};
                    end else begin
                        rem <= {1'b0, mul_sum[WIDTH:1]};
                        quo <= {mul_sum[0], quo[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    done <= 1'b1;
                    if (is_div) begin
                        // Sign-corrected remainder of a zero divide is a itself.
                        lo       <= b_zero ? '1 : q_s;
                        hi       <= r_s;
                        div_zero <= b_zero;
                    end else begin
                        {hi, lo} <= prod_s;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

    localparam int W        = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST     = 1'b1;
`else
    localparam bit FAST     = 1'b0;
`endif
    localparam int MAX_WAIT = 100;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0, b = '0, wdata = '0;
    logic         hi_we = 1'b0, lo_we = 1'b0;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    int n_cmp = 0;
    int n_bad = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a, b, eh, el;
        logic         edz;
    } vec_t;

    vec_t vecs [8] = '{
        '{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0},
        '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0},
        '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0},
        '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0},
        '{2'b11, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1'b1},
        '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0},
        '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0},
        '{2'b10, 32'h80000000, 32'h00000000, 32'h80000000, 32'hFFFFFFFF, 1'b1}
    };

    // Reference model: plain 64-bit arithmetic from the architectural rules.
    function automatic void model(input logic [1:0] m_op, input logic [W-1:0] m_a, m_b,
                                  output logic [W-1:0] e_hi, e_lo, output logic e_dz);
        longint      sa, sb;
        logic [63:0] ua, ub, t;
        sa = longint'($signed(m_a));
        sb = longint'($signed(m_b));
        ua = {32'b0, m_a};
        ub = {32'b0, m_b};
        e_dz = 1'b0;
        case (m_op)
            2'b00: begin t = sa * sb; e_hi = t[63:32]; e_lo = t[31:0]; end
            2'b01: begin t = ua * ub; e_hi = t[63:32]; e_lo = t[31:0]; end
            default: begin
                if (m_b == 0) begin
                    e_dz = 1'b1; e_lo = '1; e_hi = m_a;
                end else if (m_op == 2'b10) begin
                    t = sa / sb; e_lo = t[31:0];
                    t = sa % sb; e_hi = t[31:0];
                end else begin
                    t = ua / ub; e_lo = t[31:0];
                    t = ua % ub; e_hi = t[31:0];
                end
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [1:0] m_op);
        return (FAST && !m_op[1]) ? 1 : W + 1;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h00000000;
            1:       return 32'h80000000;
            2:       return 32'hFFFFFFFF;
            3:       return 32'h00000001;
            default: return $urandom;
        endcase
    endfunction

    // Drive a request; returns #1 after the accepting edge.
    task automatic start_op(input logic [1:0] s_op, input logic [W-1:0] s_a, s_b);
        @(negedge clk);
        start = 1'b1; op = s_op; a = s_a; b = s_b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts edges after the accept until done; lat=0 means the bound expired.
    task automatic wait_done(output int lat, output bit busy_ok, output bit stable_ok);
        logic [W-1:0] h0, l0;
        h0 = hi; l0 = lo; lat = 0;
        busy_ok = busy; stable_ok = 1'b1;
        for (int c = 1; c <= MAX_WAIT; c++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = c;
                if (busy) busy_ok = 1'b0;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            if (hi !== h0 || lo !== l0) stable_ok = 1'b0;
        end
    endtask

    task automatic exec_op(input logic [1:0] x_op, input logic [W-1:0] x_a, x_b,
                           output logic [W-1:0] o_hi, o_lo, output logic o_dz,
                           output int lat, output bit busy_ok, output bit stable_ok);
        start_op(x_op, x_a, x_b);
        wait_done(lat, busy_ok, stable_ok);
        o_hi = hi; o_lo = lo; o_dz = div_zero;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (hi !== '0)      begin n_bad++; $display("FAIL reset_hi: got %h want 0", hi); end
        n_cmp++; if (lo !== '0)      begin n_bad++; $display("FAIL reset_lo: got %h want 0", lo); end
        n_cmp++; if (busy !== 1'b0)  begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0)  begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (div_zero !== 1'b0) begin n_bad++; $display("FAIL reset_div_zero: got %b want 0", div_zero); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_directed();
        logic [W-1:0] rh, rl;
        logic         rdz;
        int           lat;
        bit           bok, sok;
        foreach (vecs[i]) begin
            exec_op(vecs[i].op, vecs[i].a, vecs[i].b, rh, rl, rdz, lat, bok, sok);
            n_cmp++; if (lat !== exp_lat(vecs[i].op)) begin n_bad++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, exp_lat(vecs[i].op)); end
            n_cmp++; if (!bok) begin n_bad++; $display("FAIL dir%0d_busy: got busy pattern wrong want high until done", i); end
            n_cmp++; if (!sok) begin n_bad++; $display("FAIL dir%0d_stable: got hi/lo change while busy want stable", i); end
            n_cmp++; if (rh !== vecs[i].eh) begin n_bad++; $display("FAIL dir%0d_hi: got %h want %h", i, rh, vecs[i].eh); end
            n_cmp++; if (rl !== vecs[i].el) begin n_bad++; $display("FAIL dir%0d_lo: got %h want %h", i, rl, vecs[i].el); end
            n_cmp++; if (rdz !== vecs[i].edz) begin n_bad++; $display("FAIL dir%0d_div_zero: got %b want %b", i, rdz, vecs[i].edz); end
        end
    endtask

    task automatic test_div_zero_clear();
        logic [W-1:0] rh, rl, eh, el;
        logic         rdz, edz;
        int           lat;
        bit           bok, sok;
        exec_op(2'b11, 32'h64, 32'h0, rh, rl, rdz, lat, bok, sok);
        n_cmp++; if (rdz !== 1'b1) begin n_bad++; $display("FAIL dz_set: got %b want 1", rdz); end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (div_zero !== 1'b1) begin n_bad++; $display("FAIL dz_held: got %b want 1", div_zero); end
        start_op(2'b11, 32'd10, 32'd3);
        n_cmp++; if (div_zero !== 1'b0) begin n_bad++; $display("FAIL dz_clear_on_accept: got %b want 0", div_zero); end
        wait_done(lat, bok, sok);
        model(2'b11, 32'd10, 32'd3, eh, el, edz);
        n_cmp++; if ({hi, lo} !== {eh, el}) begin n_bad++; $display("FAIL dz_next_result: got %h_%h want %h_%h", hi, lo, eh, el); end
    endtask

    task automatic test_busy_ignore();
        logic [1:0]   op_main;
        logic [W-1:0] eh, el;
        logic         edz;
        int           lat, extra_done;
        bit           idle_ok;
        // Multiply finishes in one cycle in the fast build, so use divide there.
        op_main = FAST ? 2'b11 : 2'b01;
        start_op(op_main, 32'd3, 32'd4);
        lat = 0;
        for (int c = 1; c <= MAX_WAIT; c++) begin
            @(negedge clk);
            if (c == 10) begin
                start = 1'b1; op = 2'b10; a = $urandom; b = $urandom;
                hi_we = 1'b1; wdata = 32'h0000AAAA;
            end else begin
                start = 1'b0; hi_we = 1'b0;
            end
            @(posedge clk); #1;
            if (done) begin lat = c; break; end
        end
        start = 1'b0; hi_we = 1'b0;
        model(op_main, 32'd3, 32'd4, eh, el, edz);
        n_cmp++; if (lat !== exp_lat(op_main)) begin n_bad++; $display("FAIL ignore_latency: got %0d want %0d", lat, exp_lat(op_main)); end
        n_cmp++; if (hi !== eh) begin n_bad++; $display("FAIL ignore_hi: got %h want %h", hi, eh); end
        n_cmp++; if (lo !== el) begin n_bad++; $display("FAIL ignore_lo: got %h want %h", lo, el); end
        extra_done = 0; idle_ok = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) extra_done++;
            if (busy) idle_ok = 1'b0;
        end
        n_cmp++; if (extra_done !== 0) begin n_bad++; $display("FAIL ignore_no_queue_done: got %0d pulses want 0", extra_done); end
        n_cmp++; if (!idle_ok) begin n_bad++; $display("FAIL ignore_no_queue_busy: got busy want idle"); end
    endtask

    task automatic test_mt_write();
        logic [W-1:0] h0, wv, eh, el;
        logic         edz;
        int           lat;
        bit           bok, sok;
        h0 = hi;
        @(negedge clk); lo_we = 1'b1; wdata = 32'h12345678;
        @(posedge clk); #1;
        lo_we = 1'b0;
        n_cmp++; if (lo !== 32'h12345678) begin n_bad++; $display("FAIL mtlo: got %h want 12345678", lo); end
        n_cmp++; if (hi !== h0) begin n_bad++; $display("FAIL mtlo_hi_untouched: got %h want %h", hi, h0); end
        wv = $urandom;
        @(negedge clk); hi_we = 1'b1; wdata = wv;
        @(posedge clk); #1;
        hi_we = 1'b0;
        n_cmp++; if (hi !== wv) begin n_bad++; $display("FAIL mthi: got %h want %h", hi, wv); end
        // MTHI together with an accepted start: write lands, result overwrites.
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'd6; b = 32'd7; hi_we = 1'b1; wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        start = 1'b0; hi_we = 1'b0;
        n_cmp++; if (hi !== 32'hCAFEF00D) begin n_bad++; $display("FAIL mt_coincident_hi: got %h want cafef00d", hi); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mt_coincident_busy: got %b want 1", busy); end
        wait_done(lat, bok, sok);
        model(2'b01, 32'd6, 32'd7, eh, el, edz);
        n_cmp++; if ({hi, lo} !== {eh, el}) begin n_bad++; $display("FAIL mt_coincident_result: got %h_%h want %h_%h", hi, lo, eh, el); end
    endtask

    task automatic test_reset_abort();
        logic [W-1:0] ra, rb, rh, rl, eh, el;
        logic         rdz, edz;
        int           lat, pulses;
        bit           bok, sok;
        start_op(2'b10, $urandom, $urandom | 32'h1);
        repeat (14) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_cmp++; if (hi !== '0) begin n_bad++; $display("FAIL abort_hi: got %h want 0", hi); end
        n_cmp++; if (lo !== '0) begin n_bad++; $display("FAIL abort_lo: got %h want 0", lo); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL abort_done: got %b want 0", done); end
        @(negedge clk); reset = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL abort_no_done: got %0d pulses want 0", pulses); end
        ra = $urandom; rb = $urandom;
        exec_op(2'b10, ra, rb, rh, rl, rdz, lat, bok, sok);
        model(2'b10, ra, rb, eh, el, edz);
        n_cmp++; if (lat !== exp_lat(2'b10)) begin n_bad++; $display("FAIL abort_next_latency: got %0d want %0d", lat, exp_lat(2'b10)); end
        n_cmp++; if ({rh, rl} !== {eh, el}) begin n_bad++; $display("FAIL abort_next_result: got %h_%h want %h_%h", rh, rl, eh, el); end
    endtask

    task automatic test_random();
        logic [1:0]   rop;
        logic [W-1:0] ra, rb, rh, rl, eh, el;
        logic         rdz, edz;
        int           lat;
        bit           bok, sok;
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = pick();
            rb  = pick();
            exec_op(rop, ra, rb, rh, rl, rdz, lat, bok, sok);
            model(rop, ra, rb, eh, el, edz);
            n_cmp++; if (lat !== exp_lat(rop)) begin n_bad++; $display("FAIL rnd%0d_latency: op=%0d got %0d want %0d", i, rop, lat, exp_lat(rop)); end
            n_cmp++; if (rh !== eh) begin n_bad++; $display("FAIL rnd%0d_hi: op=%0d a=%h b=%h got %h want %h", i, rop, ra, rb, rh, eh); end
            n_cmp++; if (rl !== el) begin n_bad++; $display("FAIL rnd%0d_lo: op=%0d a=%h b=%h got %h want %h", i, rop, ra, rb, rl, el); end
            n_cmp++; if (rdz !== edz) begin n_bad++; $display("FAIL rnd%0d_div_zero: op=%0d got %b want %b", i, rop, rdz, edz); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_zero_clear();
        test_busy_ignore();
        test_mt_write();
        test_reset_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
